fetch_unit: RTL

- Instruction-fetch stage of the 31-instruction MIPS CPU. It holds the fetch PC, requests words from instruction memory over a req/ack handshake, and registers the returned instruction.
- It presents the instruction, its PC and PC+4 to decode.
- The imm16 output drives the 16-bit immediate extender directly.
- Handles decode stall, branch/jump redirect, a discarded in-flight fetch, and a memory-timeout watchdog.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_watchdog.sv | 40 ++++
 rtl/fetch_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset PC, fetch-stage state encoding and MIPS
// instruction field positions used by the front end.
package cpu_pkg;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding, output register empty
    FULL  = 2'd1,  // output register holds a valid instruction
    DROP  = 2'd2,  // request outstanding, its data will be thrown away
    HANG  = 2'd3   // memory timed out, fetch frozen until reset
  } fetch_state_e;

  localparam int IMM_LSB = 0;
  localparam int IMM_MSB = 15;
endpackage

// File: rtl/fetch_watchdog.sv
// Instruction-memory watchdog: counts cycles a request waits without an
// acknowledge and raises a sticky timeout flag.
//   clk, rst_n : clock, async active-low reset
//   i_req      : request active this cycle
//   i_ack      : memory acknowledge this cycle
//   o_fire     : this cycle is the one that reaches the limit (combinational)
//   o_timeout  : sticky timeout flag, cleared only by reset
module fetch_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_ack,
  output logic o_fire,
  output logic o_timeout
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic             w_wait;

  assign w_wait    = i_req & ~i_ack;
  // TIMEOUT = 0 disables the watchdog entirely.
  assign o_fire    = (TIMEOUT != 0) && w_wait && (r_cnt == LAST) && !r_timeout;
  assign o_timeout = r_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (i_ack)       r_cnt <= '0;
      else if (w_wait) r_cnt <= r_cnt + 1'b1;
      if (o_fire)      r_timeout <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues req/ack reads to
// instruction memory and registers the returned word for decode.
//   clk, rst_n            : clock, async active-low reset
//   imem_req/addr         : memory request and word address (held until ack)
//   imem_ack/rdata        : memory response
//   id_ready              : decode consumes instr this cycle
//   redir_valid/redir_pc  : branch/jump redirect
//   instr/imm16           : registered instruction and its immediate field
//   pc_out/pc_plus4       : PC of instr and PC+4
//   instr_valid           : instr/pc_out valid
//   misalign              : one-cycle pulse for a redirect target with [1:0] != 0
//   imem_timeout          : sticky memory watchdog flag
module fetch_unit #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int          TIMEOUT  = 255,
  parameter int          CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic [31:0] instr,
  output logic [15:0] imm16,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        misalign,
  output logic        imem_timeout
);
  import cpu_pkg::*;

  fetch_state_e r_state;
  logic [31:0]  r_fetch_pc, r_hold_addr, r_instr, r_pc_out;
  logic         r_valid, r_misalign;
  logic         w_req, w_fire;
  logic [31:0]  w_addr, w_redir_pc;

  // FULL only issues the next read when decode is draining the register and
  // no redirect is about to make that read pointless.
  assign w_req = (r_state == FETCH) || (r_state == DROP) ||
                 ((r_state == FULL) && id_ready && !redir_valid);

  // In DROP the fetch PC already points at the redirect target, but the
  // memory still expects the original address until it acknowledges.
  assign w_addr     = (r_state == DROP) ? r_hold_addr : r_fetch_pc;
  assign w_redir_pc = {redir_pc[31:2], 2'b00};

  assign imem_req     = w_req & rst_n;
  assign imem_addr    = {w_addr[31:2], 2'b00};
  assign instr        = r_instr;
  assign imm16        = r_instr[IMM_MSB:IMM_LSB];
  assign pc_out       = r_pc_out;
  assign pc_plus4     = r_pc_out + 32'd4;
  assign instr_valid  = r_valid;
  assign misalign     = r_misalign;

  fetch_watchdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (imem_req),
    .i_ack     (imem_ack),
    .o_fire    (w_fire),
    .o_timeout (imem_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FETCH;
      r_fetch_pc  <= RESET_PC;
      r_hold_addr <= '0;
      r_instr     <= '0;
      r_pc_out    <= '0;
      r_valid     <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      if (r_state == HANG) begin
        r_state <= HANG;
      end else if (w_fire) begin
        r_state <= HANG;
        r_valid <= 1'b0;
      end else if (redir_valid) begin
        r_fetch_pc <= w_redir_pc;
        r_valid    <= 1'b0;
        r_misalign <= |redir_pc[1:0];
        if (w_req && !imem_ack) begin
          r_state <= DROP;
          // A second redirect in DROP must not lose the in-flight address.
          if (r_state != DROP) r_hold_addr <= r_fetch_pc;
        end else begin
          r_state <= FETCH;
        end
      end else if (r_state == DROP) begin
        if (imem_ack) r_state <= FETCH;
      end else if (w_req && imem_ack) begin
        r_instr    <= imem_rdata;
        r_pc_out   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_valid    <= 1'b1;
        r_state    <= FULL;
      end else if ((r_state == FULL) && id_ready) begin
        r_valid <= 1'b0;
        r_state <= FETCH;
      end
    end
  end
endmodule
